// File: rtl/robin_pkg.sv
// robin_pkg: shared definitions for the robin load/store path.
// Holds the access-size encodings, the load/store sequencer state constants,
// the latched request payload and a size-to-byte-count helper.
package robin_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;   // byte index within a long
    localparam int unsigned CNT_W  = 3;   // byte counter, must reach 4

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_LONG = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // Request fields kept for the lifetime of one access
    typedef struct packed {
        size_e              size;
        logic               sgn;
        logic [DATA_W-1:0]  wdata;
    } lsu_req_t;

    // Number of bytes moved for an access size (0 for the reserved code)
    function automatic logic [CNT_W-1:0] size_bytes(input size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_LONG: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_read_tracker.sv
// lsu_read_tracker: DEPTH-deep valid/index shift register that follows each
// issued read address through the memory latency.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   issue, issue_idx  a read address is on the memory port this cycle, with its byte index
//   cap, cap_idx      the byte for cap_idx is on mem_data_out this cycle
module lsu_read_tracker
    import robin_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [IDX_W-1:0] issue_idx,
    output logic             cap,
    output logic [IDX_W-1:0] cap_idx
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    // Tag pipeline; reset drops every in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) idx[i] <= '0;
        end else begin
            vld[0] <= issue;
            idx[0] <= issue_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign cap     = vld[DEPTH-1];
    assign cap_idx = idx[DEPTH-1];

endmodule

// File: rtl/loadstore_unit.sv
// loadstore_unit: byte-serial big-endian load/store sequencer for the robin core.
// Converts one byte/half/long request into per-byte accesses on an 8-bit memory
// port; reads are pipelined one address per cycle across MEM_LATENCY.
// Optional build macro: LSU_ALIGN_CHECK_EN rejects misaligned halves and longs.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata  request fields
//   resp_valid/resp_data/resp_err     one-cycle completion with load data / reject flag
//   mem_raddr, mem_data_out           read address and returned byte
//   mem_waddr, mem_data_in, mem_write write address, data and strobe
module loadstore_unit
    import robin_pkg::*;
#(
    parameter int unsigned addr_width  = 9,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [addr_width-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic [addr_width-1:0] mem_raddr,
    input  logic [BYTE_W-1:0]     mem_data_out,
    output logic [addr_width-1:0] mem_waddr,
    output logic [BYTE_W-1:0]     mem_data_in,
    output logic                  mem_write
);

    lsu_state_e            state, state_d;
    lsu_req_t              req_q, req_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic                  issue_q, issue_d;
    logic [IDX_W-1:0]      issue_idx_q, issue_idx_d;
    logic                  cap;
    logic [IDX_W-1:0]      cap_idx;
    logic [CNT_W-1:0]      n_req, n_q;
    logic                  reject_c;

    logic                  req_ready_d, resp_valid_d, resp_err_d, mem_write_d;
    logic [DATA_W-1:0]     resp_data_d;
    logic [addr_width-1:0] mem_raddr_d, mem_waddr_d;
    logic [BYTE_W-1:0]     mem_data_in_d;

    // Byte k of the right-aligned n-byte store value; byte 0 is the most significant
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [DATA_W-1:0] data,
                                                    input logic [CNT_W-1:0]  n,
                                                    input logic [CNT_W-1:0]  k);
        logic [IDX_W-1:0] pos;
        pos = IDX_W'(n - k - 3'd1);
        return BYTE_W'(data >> {pos, 3'b000});
    endfunction

    // Zero/sign extension of the assembled load value
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] r,
                                                 input size_e             size,
                                                 input logic              sgn);
        case (size)
            SIZE_BYTE: return {{24{sgn & r[7]}}, r[7:0]};
            SIZE_HALF: return {{16{sgn & r[15]}}, r[15:0]};
            default:   return r;
        endcase
    endfunction

    assign n_req = size_bytes(size_e'(req_size));
    assign n_q   = size_bytes(req_q.size);

    // Requests answered with resp_err and no memory traffic
    always_comb begin
        reject_c = (size_e'(req_size) == SIZE_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
        if (size_e'(req_size) == SIZE_HALF && req_addr[0])          reject_c = 1'b1;
        if (size_e'(req_size) == SIZE_LONG && req_addr[1:0] != 2'b00) reject_c = 1'b1;
`endif
    end

    lsu_read_tracker #(.DEPTH(MEM_LATENCY)) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue_q),
        .issue_idx (issue_idx_q),
        .cap       (cap),
        .cap_idx   (cap_idx)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_d       = state;
        req_d         = req_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        issue_d       = 1'b0;
        issue_idx_d   = issue_idx_q;
        req_ready_d   = 1'b0;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_data_d   = resp_data;
        mem_raddr_d   = mem_raddr;
        mem_waddr_d   = mem_waddr;
        mem_data_in_d = mem_data_in;
        mem_write_d   = 1'b0;
        // Captured bytes shift in from the right, so byte 0 ends up most significant
        result_d      = cap ? {result_q[DATA_W-BYTE_W-1:0], mem_data_out} : result_q;

        case (state)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_d.size  = size_e'(req_size);
                    req_d.sgn   = req_signed;
                    req_d.wdata = req_wdata;
                    addr_d      = req_addr;
                    cnt_d       = 3'd1;
                    req_ready_d = 1'b0;
                    if (reject_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else if (req_write) begin
                        state_d       = ST_WRITE;
                        mem_write_d   = 1'b1;
                        mem_waddr_d   = req_addr;
                        mem_data_in_d = pick_byte(req_wdata, n_req, 3'd0);
                    end else begin
                        state_d     = (n_req == 3'd1) ? ST_DRAIN : ST_ISSUE;
                        mem_raddr_d = req_addr;
                        issue_d     = 1'b1;
                        issue_idx_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                mem_raddr_d = addr_q + addr_width'(cnt_q);
                issue_d     = 1'b1;
                issue_idx_d = IDX_W'(cnt_q);
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == n_q - 3'd1) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Respond on the same edge that captures the final byte
                if (cap && cap_idx == IDX_W'(n_q - 3'd1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = extend(result_d, req_q.size, req_q.sgn);
                end
            end
            ST_WRITE: begin
                if (cnt_q == n_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                end else begin
                    mem_write_d   = 1'b1;
                    mem_waddr_d   = addr_q + addr_width'(cnt_q);
                    mem_data_in_d = pick_byte(req_q.wdata, n_q, cnt_q);
                    cnt_d         = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            issue_q     <= 1'b0;
            issue_idx_q <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_data   <= '0;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
        end else begin
            state       <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            issue_q     <= issue_d;
            issue_idx_q <= issue_idx_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_err    <= resp_err_d;
            resp_data   <= resp_data_d;
            mem_raddr   <= mem_raddr_d;
            mem_waddr   <= mem_waddr_d;
            mem_data_in <= mem_data_in_d;
            mem_write   <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_loadstore_unit.sv
// tb_loadstore_unit: self-checking bench for loadstore_unit with a latency
// memory model and a byte-array reference of memory contents.
// Honours LSU_ALIGN_CHECK_EN when the build defines it.
module tb_loadstore_unit;

    localparam int unsigned AW  = 9;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_data_out;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_data_in;
    logic          mem_write;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;

    // Environment memory (written only here) and the reference image
    logic [7:0]    mem [512];
    logic [7:0]    ref_mem [512];
    logic [AW-1:0] rpipe [4];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [7:0]    poke_data = '0;

    always #5 clk = ~clk;

    loadstore_unit #(.addr_width(AW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .mem_raddr(mem_raddr), .mem_data_out(mem_data_out),
        .mem_waddr(mem_waddr), .mem_data_in(mem_data_in), .mem_write(mem_write)
    );

    // Read data appears LAT cycles after its address
    assign mem_data_out = mem[rpipe[LAT-1]];

    always @(posedge clk) begin
        rpipe[0] <= mem_raddr;
        for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
        if (mem_write) begin
            mem[mem_waddr] <= mem_data_in;
            wr_cnt <= wr_cnt + 1;
        end
        if (poke_en) mem[poke_addr] <= poke_data;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] v);
        ref_mem[a] = v;
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"},  32'(req_ready),   32'd1);
        chk({tag, "_rvalid"}, 32'(resp_valid),  32'd0);
        chk({tag, "_rerr"},   32'(resp_err),    32'd0);
        chk({tag, "_rdata"},  resp_data,        32'd0);
        chk({tag, "_mwrite"}, 32'(mem_write),   32'd0);
        chk({tag, "_raddr"},  32'(mem_raddr),   32'd0);
        chk({tag, "_waddr"},  32'(mem_waddr),   32'd0);
        chk({tag, "_wdata"},  32'(mem_data_in), 32'd0);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_reject(input logic [1:0] sz, input logic [AW-1:0] a);
        logic r;
        r = (sz == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
        if (sz == 2'd1 && a[0]) r = 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'b00) r = 1'b1;
`else
        if (a == '1 && sz == 2'd3) r = 1'b1;
`endif
        return r;
    endfunction

    // Expected load value from the reference image
    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [AW-1:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[AW'(32'(a) + k)]);
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [7:0] store_byte(input logic [31:0] wd, input int n, input int k);
        return 8'(wd >> (8*(n-1-k)));
    endfunction

    // One complete request with per-cycle observation
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [AW-1:0] a, input logic [31:0] wd);
        int n, lat, cyc, wr0, rs0, tries;
        logic rej;
        logic [31:0] expv;
        logic [AW-1:0] ra_before;
        logic [AW-1:0] ra_log [8];
        logic [AW-1:0] wa_log [8];
        logic [7:0]    di_log [8];
        logic          we_log [8];
        for (int i = 0; i < 8; i++) begin
            ra_log[i] = '0; wa_log[i] = '0; di_log[i] = '0; we_log[i] = 1'b0;
        end
        n    = nbytes(sz);
        rej  = is_reject(sz, a);
        expv = (rej || wr) ? 32'd0 : model_load(sz, sg, a);
        lat  = rej ? 1 : (wr ? n + 1 : n + int'(LAT) + 1);

        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        tries = 0;
        while (!req_ready && tries < 50) begin @(negedge clk); tries++; end
        ra_before = mem_raddr;
        wr0 = wr_cnt;
        rs0 = resp_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i < 40; i++) begin
            if (cyc < 8) begin
                ra_log[cyc] = mem_raddr; wa_log[cyc] = mem_waddr;
                di_log[cyc] = mem_data_in; we_log[cyc] = mem_write;
            end
            if (resp_valid) break;
            @(negedge clk);
            cyc++;
        end

        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_err"}, 32'(resp_err), 32'(rej));
        chk({tag, "_data"}, resp_data, expv);
        if (rej) chk({tag, "_no_raddr"}, 32'(mem_raddr), 32'(ra_before));
        if (!rej && !wr)
            for (int k = 0; k < n; k++)
                chk({tag, "_raddr"}, 32'(ra_log[1+k]), 32'(AW'(32'(a) + k)));
        if (!rej && wr) begin
            for (int k = 0; k < n; k++) begin
                chk({tag, "_wstrobe"}, 32'(we_log[1+k]), 32'd1);
                chk({tag, "_waddr"},   32'(wa_log[1+k]), 32'(AW'(32'(a) + k)));
                chk({tag, "_wbyte"},   32'(di_log[1+k]), 32'(store_byte(wd, n, k)));
            end
            chk({tag, "_wstrobe_end"}, 32'(we_log[n+1]), 32'd0);
            for (int k = 0; k < n; k++) ref_mem[AW'(32'(a) + k)] = store_byte(wd, n, k);
            for (int k = 0; k < n; k++)
                chk({tag, "_memimg"}, 32'(mem[AW'(32'(a) + k)]), 32'(ref_mem[AW'(32'(a) + k)]));
        end
        chk({tag, "_nwrites"}, 32'(wr_cnt - wr0), (wr && !rej) ? 32'(n) : 32'd0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, "_npulse"}, 32'(resp_cnt - rs0), 32'd1);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin : stim
        int wr0, rs0, tries, rr;
        logic [31:0] expv;
        logic        rv [16];
        logic        mw [16];
        logic        rdy [16];
        logic [31:0] rd [16];
        logic [AW-1:0] wa [16];
        logic [7:0]  di [16];
        int overlap;

        // Reset and fill memory with random contents
        #2 reset = 1'b1;
        #1 chk_reset_values("reset");
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            ref_mem[i] = 8'($urandom);
            poke_en = 1'b1; poke_addr = AW'(i); poke_data = ref_mem[i];
        end
        @(negedge clk);
        poke_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values("post_reset");

        // Long load, big-endian assembly
        poke(9'h010, 8'h81); poke(9'h011, 8'h22); poke(9'h012, 8'h33); poke(9'h013, 8'h44);
        run_req("ld_long", 1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        chk("ld_long_value", resp_data, 32'h81223344);

        // Signed and unsigned byte
        poke(9'h020, 8'h9C);
        run_req("ld_byte_s", 1'b0, 2'd0, 1'b1, 9'h020, 32'h0);
        run_req("ld_byte_u", 1'b0, 2'd0, 1'b0, 9'h020, 32'h0);

        // Half store wrapping past the top of the address space
        run_req("st_half_wrap", 1'b1, 2'd1, 1'b0, 9'h1FF, 32'h1234ABCD);
        chk("st_half_wrap_hi", 32'(mem[9'h1FF]), 32'h000000AB);
        chk("st_half_wrap_lo", 32'(mem[9'h000]), 32'h000000CD);

        // Misaligned long, signed half, reserved size, long wrap
        run_req("ld_long_002", 1'b0, 2'd2, 1'b1, 9'h002, 32'h0);
        run_req("st_long_002", 1'b1, 2'd2, 1'b0, 9'h002, 32'hCAFEF00D);
        run_req("ld_half_odd", 1'b0, 2'd1, 1'b1, 9'h0F1, 32'h0);
        run_req("rsvd_ld", 1'b0, 2'd3, 1'b0, 9'h040, 32'h0);
        run_req("rsvd_st", 1'b1, 2'd3, 1'b0, 9'h040, 32'hFFFFFFFF);
        run_req("ld_long_wrap", 1'b0, 2'd2, 1'b0, 9'h1FC, 32'h0);

        // Reset in the middle of a long store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 9'h0A0; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        tries = 0;
        while (!req_ready && tries < 50) begin @(negedge clk); tries++; end
        wr0 = wr_cnt;
        rs0 = resp_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_strobe", 32'(mem_write), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_mid_async_drop", 32'(mem_write), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values("rst_mid");
        chk("rst_mid_nwrites", 32'(wr_cnt - wr0), 32'd1);
        chk("rst_mid_nresp", 32'(resp_cnt - rs0), 32'd0);
        ref_mem[9'h0A0] = 8'hDE;
        chk("rst_mid_byte0", 32'(mem[9'h0A0]), 32'h000000DE);
        chk("rst_mid_byte1", 32'(mem[9'h0A1]), 32'(ref_mem[9'h0A1]));

        // Back-to-back load then store with req_valid held high
        expv = model_load(2'd1, 1'b0, 9'h0C0);
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 9'h0C0; req_wdata = 32'h0; req_valid = 1'b1;
        tries = 0;
        while (!req_ready && tries < 50) begin @(negedge clk); tries++; end
        @(posedge clk);
        for (int c = 1; c < 13; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_write = 1'b1; req_size = 2'd0; req_addr = 9'h0C8; req_wdata = 32'h0000005A;
            end
            if (c == 7) req_valid = 1'b0;
            rv[c] = resp_valid; mw[c] = mem_write; rdy[c] = req_ready;
            rd[c] = resp_data; wa[c] = mem_waddr; di[c] = mem_data_in;
        end
        rr = 2 + int'(LAT) + 1;
        chk("b2b_ld_before", 32'(rv[rr-1]), 32'd0);
        chk("b2b_ld_resp", 32'(rv[rr]), 32'd1);
        chk("b2b_ld_data", rd[rr], expv);
        chk("b2b_ld_once", 32'(rv[rr+1]), 32'd0);
        chk("b2b_busy_at_resp", 32'(rdy[rr]), 32'd0);
        chk("b2b_idle_after", 32'(rdy[rr+1]), 32'd1);
        chk("b2b_busy_again", 32'(rdy[rr+2]), 32'd0);
        overlap = 0;
        for (int c = 1; c <= rr + 1; c++) if (mw[c]) overlap++;
        chk("b2b_no_overlap", 32'(overlap), 32'd0);
        chk("b2b_st_strobe", 32'(mw[rr+2]), 32'd1);
        chk("b2b_st_addr", 32'(wa[rr+2]), 32'h0C8);
        chk("b2b_st_byte", 32'(di[rr+2]), 32'h5A);
        chk("b2b_st_resp", 32'(rv[rr+3]), 32'd1);
        chk("b2b_st_strobe_end", 32'(mw[rr+3]), 32'd0);
        ref_mem[9'h0C8] = 8'h5A;
        chk("b2b_memimg", 32'(mem[9'h0C8]), 32'h5A);
        @(negedge clk);

        // Randomized requests checked against the reference image
        for (int t = 0; t < 60; t++) begin
            run_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                    AW'($urandom), $urandom);
        end

        // Full-image sweep: every store must have landed where the model says
        for (int i = 0; i < 512; i += 37)
            chk("final_memimg", 32'(mem[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
